// File: rtl/roll_scan_pkg.sv
// Shared types and constants for the paper-roll grid scan controller.
// Holds the FSM state encoding, neighbour-count width and default threshold.
package roll_scan_pkg;

    localparam int NCNT_W         = 4;
    localparam int THRESH_DEFAULT = 4;
    localparam int SUM_W          = 32;
    localparam int PASS_W         = 16;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PRIME_RD  = 4'd1,
        S_PRIME_CAP = 4'd2,
        S_ROW_RD    = 4'd3,
        S_ROW_CAP   = 4'd4,
        S_EVAL      = 4'd5,
        S_WRITE     = 4'd6,
        S_PASS_END  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    // Number of set bits among the eight neighbours of one cell.
    function automatic logic [NCNT_W-1:0] nbr_count(input logic [7:0] n);
        logic [NCNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + NCNT_W'(n[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/roll_scan_ctrl_eval.sv
// Combinational row evaluator: flags rolls in the middle row with fewer than
// THRESH occupied neighbours and counts them.
module roll_row_eval
    import roll_scan_pkg::*;
#(
    parameter int COLS   = 140,
    parameter int THRESH = THRESH_DEFAULT,
    parameter int CW     = $clog2(COLS + 1)
) (
    input  logic [COLS-1:0] i_prev,
    input  logic [COLS-1:0] i_cur,
    input  logic [COLS-1:0] i_nxt,
    output logic [COLS-1:0] o_mask,
    output logic [CW-1:0]   o_count
);

    // One zero column on each side so edge columns see empty neighbours.
    logic [COLS+1:0] w_prev_pad;
    logic [COLS+1:0] w_cur_pad;
    logic [COLS+1:0] w_nxt_pad;

    assign w_prev_pad = {1'b0, i_prev, 1'b0};
    assign w_cur_pad  = {1'b0, i_cur, 1'b0};
    assign w_nxt_pad  = {1'b0, i_nxt, 1'b0};

    always_comb begin
        logic [NCNT_W-1:0] v_n;
        v_n     = '0;
        o_mask  = '0;
        o_count = '0;
        for (int c = 0; c < COLS; c++) begin
            v_n = nbr_count({w_prev_pad[c], w_prev_pad[c+1], w_prev_pad[c+2],
                             w_cur_pad[c],                   w_cur_pad[c+2],
                             w_nxt_pad[c],  w_nxt_pad[c+1],  w_nxt_pad[c+2]});
            o_mask[c] = i_cur[c] && (v_n < NCNT_W'(THRESH));
            o_count   = o_count + CW'(o_mask[c]);
        end
    end

endmodule

// File: rtl/roll_scan_ctrl.sv
// Row-streaming scan controller: 3-row line buffer over a single-port row
// memory, counts accessible rolls and optionally removes them until stable.
module roll_scan_ctrl
    import roll_scan_pkg::*;
#(
    parameter int ROWS   = 140,
    parameter int COLS   = 140,
    parameter int AW     = 8,
    parameter int THRESH = THRESH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [COLS-1:0]   mem_rdata,
    output logic              mem_wr_en,
    output logic [COLS-1:0]   mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [3:0]        dbg_state
);

    localparam int              CW       = $clog2(COLS + 1);
    localparam logic [AW:0]     ROWS_W   = (AW + 1)'(ROWS);
    localparam logic [AW-1:0]   LAST_ROW = AW'(ROWS - 1);

    state_t             r_state;
    logic               r_mode;
    logic [COLS-1:0]    r_prev;
    logic [COLS-1:0]    r_cur;
    logic [COLS-1:0]    r_nxt;
    logic [AW-1:0]      r_row;
    logic               r_rd_en;
    logic [AW-1:0]      r_addr;
    logic               r_wr_en;
    logic [COLS-1:0]    r_wdata;
    logic               r_busy;
    logic               r_done;
    logic [SUM_W-1:0]   r_sum;
    logic [PASS_W-1:0]  r_pass_cnt;
    logic [SUM_W-1:0]   r_pass_removed;

    logic [COLS-1:0]    w_mask;
    logic [CW-1:0]      w_count;
    logic               w_last_row;
    logic [AW:0]        w_row_inc;
    logic [AW:0]        w_row_inc2;
    logic               w_adv_rd;

    roll_row_eval #(
        .COLS   (COLS),
        .THRESH (THRESH),
        .CW     (CW)
    ) u_eval (
        .i_prev  (r_prev),
        .i_cur   (r_cur),
        .i_nxt   (r_nxt),
        .o_mask  (w_mask),
        .o_count (w_count)
    );

    // When stepping to row r+1, row r+2 is prefetched only if it exists.
    assign w_last_row = (r_row == LAST_ROW);
    assign w_row_inc  = {1'b0, r_row} + (AW + 1)'(1);
    assign w_row_inc2 = {1'b0, r_row} + (AW + 1)'(2);
    assign w_adv_rd   = (w_row_inc2 < ROWS_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_prev         <= '0;
            r_cur          <= '0;
            r_nxt          <= '0;
            r_row          <= '0;
            r_rd_en        <= 1'b0;
            r_addr         <= '0;
            r_wr_en        <= 1'b0;
            r_wdata        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sum          <= '0;
            r_pass_cnt     <= '0;
            r_pass_removed <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode         <= mode;
                        r_sum          <= '0;
                        r_pass_cnt     <= '0;
                        r_pass_removed <= '0;
                        r_done         <= 1'b0;
                        r_busy         <= 1'b1;
                        r_rd_en        <= 1'b1;
                        r_addr         <= '0;
                        r_state        <= S_PRIME_RD;
                    end
                end
                S_PRIME_RD: begin
                    r_rd_en <= 1'b0;
                    r_prev  <= '0;
                    r_cur   <= '0;
                    r_state <= S_PRIME_CAP;
                end
                S_PRIME_CAP: begin
                    r_nxt   <= mem_rdata;
                    r_row   <= '0;
                    r_rd_en <= 1'b1;
                    r_addr  <= AW'(1);
                    r_state <= S_ROW_RD;
                end
                S_ROW_RD: begin
                    r_prev  <= r_cur;
                    r_cur   <= r_nxt;
                    r_rd_en <= 1'b0;
                    r_addr  <= '0;
                    r_state <= S_ROW_CAP;
                end
                S_ROW_CAP: begin
                    r_nxt   <= w_last_row ? '0 : mem_rdata;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_sum <= r_sum + SUM_W'(w_count);
                    if (r_mode) begin
                        r_pass_removed <= r_pass_removed + SUM_W'(w_count);
                    end
                    // Clearing cur in place lets the next row see this row's removals.
                    if (r_mode && (|w_mask)) begin
                        r_wr_en <= 1'b1;
                        r_addr  <= r_row;
                        r_wdata <= r_cur & ~w_mask;
                        r_cur   <= r_cur & ~w_mask;
                        r_state <= S_WRITE;
                    end else if (!w_last_row) begin
                        r_row   <= w_row_inc[AW-1:0];
                        r_rd_en <= w_adv_rd;
                        r_addr  <= w_adv_rd ? w_row_inc2[AW-1:0] : '0;
                        r_state <= S_ROW_RD;
                    end else begin
                        r_state <= S_PASS_END;
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_wdata <= '0;
                    if (!w_last_row) begin
                        r_row   <= w_row_inc[AW-1:0];
                        r_rd_en <= w_adv_rd;
                        r_addr  <= w_adv_rd ? w_row_inc2[AW-1:0] : '0;
                        r_state <= S_ROW_RD;
                    end else begin
                        r_addr  <= '0;
                        r_state <= S_PASS_END;
                    end
                end
                S_PASS_END: begin
                    r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                    if (r_mode && (r_pass_removed != '0)) begin
                        r_pass_removed <= '0;
                        r_rd_en        <= 1'b1;
                        r_addr         <= '0;
                        r_state        <= S_PRIME_RD;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_addr;
    assign mem_wr_en = r_wr_en;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign pass_cnt  = r_pass_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_roll_scan_ctrl.sv
// Bench for roll_scan_ctrl: a 10x10 and a 3x3 instance, each with a row
// memory model, checked against a grid-level reference of the scan rules.
module tb_roll_scan_ctrl;

  localparam int THRESH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit   sel     = 1'b0;
  logic start_s = 1'b0;
  logic mode_s  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // 10x10 instance
  logic        start10, rd10, wr10, busy10, done10;
  logic [3:0]  addr10, st10;
  logic [9:0]  rdata10 = '0;
  logic [9:0]  wdata10;
  logic [31:0] sum10;
  logic [15:0] pc10;

  // 3x3 instance
  logic        start3, rd3, wr3, busy3, done3;
  logic [1:0]  addr3;
  logic [3:0]  st3;
  logic [2:0]  rdata3 = '0;
  logic [2:0]  wdata3;
  logic [31:0] sum3;
  logic [15:0] pc3;

  assign start10 = start_s & ~sel;
  assign start3  = start_s & sel;

  roll_scan_ctrl #(.ROWS(10), .COLS(10), .AW(4), .THRESH(THRESH)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .mode(mode_s),
    .mem_rd_en(rd10), .mem_addr(addr10), .mem_rdata(rdata10),
    .mem_wr_en(wr10), .mem_wdata(wdata10),
    .busy(busy10), .done(done10), .sum(sum10), .pass_cnt(pc10), .dbg_state(st10)
  );

  roll_scan_ctrl #(.ROWS(3), .COLS(3), .AW(2), .THRESH(THRESH)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode_s),
    .mem_rd_en(rd3), .mem_addr(addr3), .mem_rdata(rdata3),
    .mem_wr_en(wr3), .mem_wdata(wdata3),
    .busy(busy3), .done(done3), .sum(sum3), .pass_cnt(pc3), .dbg_state(st3)
  );

  logic        s_busy, s_done;
  logic [31:0] s_sum;
  logic [15:0] s_pc;
  assign s_busy = sel ? busy3 : busy10;
  assign s_done = sel ? done3 : done10;
  assign s_sum  = sel ? sum3  : sum10;
  assign s_pc   = sel ? pc3   : pc10;

  // Row memories: one-cycle read latency, write at the strobe edge
  logic [9:0] mem10 [10];
  logic [9:0] img10 [10];
  logic [2:0] mem3  [3];
  logic [2:0] img3  [3];
  bit load10 = 1'b0;
  bit load3  = 1'b0;
  int wcnt10 = 0, viol10 = 0, wcnt3 = 0, viol3 = 0;

  always @(posedge clk) begin
    if (load10) begin
      for (int i = 0; i < 10; i++) mem10[i] = img10[i];
    end else begin
      if (rd10) begin
        if (addr10 < 4'd10) rdata10 <= mem10[addr10];
        else begin rdata10 <= '0; viol10++; end
      end
      if (rd10 && wr10) viol10++;
      if (wr10) begin mem10[addr10] = wdata10; wcnt10++; end
    end
  end

  always @(posedge clk) begin
    if (load3) begin
      for (int i = 0; i < 3; i++) mem3[i] = img3[i];
    end else begin
      if (rd3) begin
        if (addr3 < 2'd3) rdata3 <= mem3[addr3];
        else begin rdata3 <= '0; viol3++; end
      end
      if (rd3 && wr3) viol3++;
      if (wr3) begin mem3[addr3] = wdata3; wcnt3++; end
    end
  end

  // Reference grid: mg[row][col]
  bit mg [10][10];

  function automatic int nbrs(input int r, input int c, input int nr, input int nc);
    int n;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < nr && c + dc >= 0 && c + dc < nc)
          n += int'(mg[r+dr][c+dc]);
    return n;
  endfunction

  // Rows are scanned top to bottom; a row's removals are decided on the whole
  // row first and then applied, so rows below see them within the same pass.
  task automatic model_run(input int nr, input int nc, input bit md,
                           output int s, output int pc, output int cyc, output int wr);
    int removed, cnt;
    bit rem [10];
    s = 0; pc = 0; cyc = 0; wr = 0;
    do begin
      pc++;
      removed = 0;
      cyc += 3 + 3 * nr;
      for (int r = 0; r < nr; r++) begin
        cnt = 0;
        for (int c = 0; c < nc; c++) begin
          rem[c] = mg[r][c] && (nbrs(r, c, nr, nc) < THRESH);
          cnt += int'(rem[c]);
        end
        s += cnt;
        if (md && cnt > 0) begin
          for (int c = 0; c < nc; c++) if (rem[c]) mg[r][c] = 1'b0;
          wr++;
          cyc++;
          removed += cnt;
        end
      end
    end while (md && removed != 0);
    cyc += 1;
  endtask

  task automatic do_load(input bit use3);
    @(negedge clk);
    if (use3) load3 = 1'b1; else load10 = 1'b1;
    @(negedge clk);
    load3 = 1'b0; load10 = 1'b0;
  endtask

  task automatic rand_img10();
    int dens;
    dens = $urandom_range(0, 2);
    for (int r = 0; r < 10; r++) begin
      case (dens)
        0: img10[r] = 10'($urandom & $urandom);
        1: img10[r] = 10'($urandom);
        default: img10[r] = 10'($urandom | $urandom);
      endcase
    end
  endtask

  // Start one run on the selected instance and check it against the model.
  task automatic run_check(input string name, input bit use3, input bit md,
                           input int inject, output int cyc);
    int nr, es, epc, ecyc, ewr, w0, v0, bad;
    bit seen;
    nr = use3 ? 3 : 10;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        mg[r][c] = (r < nr && c < nr) ? (use3 ? mem3[r][c] : mem10[r][c]) : 1'b0;
    model_run(nr, nr, md, es, epc, ecyc, ewr);
    w0 = use3 ? wcnt3 : wcnt10;
    v0 = use3 ? viol3 : viol10;

    @(negedge clk);
    sel = use3; mode_s = md; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    n_cmp++;
    if ({s_busy, s_done} !== 2'b10) begin
      n_bad++; $display("FAIL %s_start_flags: busy,done=%b required 10", name, {s_busy, s_done});
    end

    cyc = 0; seen = 1'b0;
    while (cyc < 20000 && !seen) begin
      @(posedge clk);
      cyc++;
      #1;
      if (s_done) seen = 1'b1;
      else if (cyc == inject) begin start_s = 1'b1; mode_s = ~md; end
      else begin start_s = 1'b0; mode_s = md; end
    end
    start_s = 1'b0; mode_s = md;

    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s_timeout: done not seen within %0d cycles", name, cyc);
      return;
    end
    n_cmp++;
    if (cyc !== ecyc) begin
      n_bad++; $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, ecyc);
    end
    n_cmp++;
    if (s_sum !== 32'(es)) begin
      n_bad++; $display("FAIL %s_sum: got %0d required %0d", name, s_sum, es);
    end
    n_cmp++;
    if (s_pc !== 16'(epc)) begin
      n_bad++; $display("FAIL %s_pass_cnt: got %0d required %0d", name, s_pc, epc);
    end
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_busy_end: got %b required 0", name, s_busy);
    end
    n_cmp++;
    if ((use3 ? wcnt3 : wcnt10) - w0 !== ewr) begin
      n_bad++; $display("FAIL %s_writes: got %0d required %0d", name, (use3 ? wcnt3 : wcnt10) - w0, ewr);
    end
    n_cmp++;
    if ((use3 ? viol3 : viol10) - v0 !== 0) begin
      n_bad++; $display("FAIL %s_protocol: got %0d violations required 0", name, (use3 ? viol3 : viol10) - v0);
    end
    bad = 0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nr; c++)
        if ((use3 ? mem3[r][c] : mem10[r][c]) !== mg[r][c]) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL %s_memory: got %0d differing cells required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy10, done10, rd10, wr10, busy3, done3, rd3, wr3} !== 8'h00) begin
      n_bad++; $display("FAIL reset_flags: got %b required 00000000",
                        {busy10, done10, rd10, wr10, busy3, done3, rd3, wr3});
    end
    n_cmp++;
    if ({sum10, pc10, sum3, pc3} !== 96'h0) begin
      n_bad++; $display("FAIL reset_counts: got sum10=%0d pc10=%0d sum3=%0d pc3=%0d required 0",
                        sum10, pc10, sum3, pc3);
    end
    n_cmp++;
    if ({addr10, wdata10, addr3, wdata3, st10, st3} !== 27'h0) begin
      n_bad++; $display("FAIL reset_mem_bus: got addr10=%0d wdata10=%0h addr3=%0d wdata3=%0h required 0",
                        addr10, wdata10, addr3, wdata3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_example();
    string ex [10];
    string s;
    int cyc;
    ex = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
           ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};
    for (int r = 0; r < 10; r++) begin
      s = ex[r];
      for (int c = 0; c < 10; c++) img10[r][c] = (s[c] == 8'h40);
    end
    do_load(1'b0);
    run_check("ex_m0", 1'b0, 1'b0, 0, cyc);
    n_cmp++;
    if ({sum10, pc10} !== {32'd13, 16'd1}) begin
      n_bad++; $display("FAIL ex_m0_const: got sum=%0d pass_cnt=%0d required 13/1", sum10, pc10);
    end
    n_cmp++;
    if (cyc !== 34) begin
      n_bad++; $display("FAIL ex_m0_34cyc: got %0d required 34", cyc);
    end
    do_load(1'b0);
    run_check("ex_m1", 1'b0, 1'b1, 0, cyc);
    n_cmp++;
    if (sum10 !== 32'd43) begin
      n_bad++; $display("FAIL ex_m1_const: got sum=%0d required 43", sum10);
    end
  endtask

  task automatic test_small();
    int cyc;
    for (int r = 0; r < 3; r++) img3[r] = 3'b111;
    do_load(1'b1);
    run_check("ones_m0", 1'b1, 1'b0, 0, cyc);
    n_cmp++;
    if (sum3 !== 32'd4) begin
      n_bad++; $display("FAIL ones_m0_const: got sum=%0d required 4", sum3);
    end
    do_load(1'b1);
    run_check("ones_m1", 1'b1, 1'b1, 0, cyc);
    n_cmp++;
    if ({sum3, pc3} !== {32'd9, 16'd3}) begin
      n_bad++; $display("FAIL ones_m1_const: got sum=%0d pass_cnt=%0d required 9/3", sum3, pc3);
    end
    n_cmp++;
    if ({mem3[0], mem3[1], mem3[2]} !== 9'h0) begin
      n_bad++; $display("FAIL ones_m1_cleared: got %b required all zero", {mem3[0], mem3[1], mem3[2]});
    end
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 3; r++) img3[r] = 3'b000;
      do_load(1'b1);
      run_check("zero", 1'b1, 1'(m), 0, cyc);
      n_cmp++;
      if ({sum3, pc3} !== {32'd0, 16'd1}) begin
        n_bad++; $display("FAIL zero_const: mode %0d got sum=%0d pass_cnt=%0d required 0/1", m, sum3, pc3);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int k = 0; k < 8; k++) begin
      rand_img10();
      do_load(1'b0);
      run_check("rand10", 1'b0, 1'($urandom_range(0, 1)), 0, cyc);
    end
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++) img3[r] = 3'($urandom);
      do_load(1'b1);
      run_check("rand3", 1'b1, 1'($urandom_range(0, 1)), 0, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    rand_img10();
    do_load(1'b0);
    run_check("restart_m0", 1'b0, 1'b0, 15, cyc);
    do_load(1'b0);
    run_check("restart_m1", 1'b0, 1'b1, 40, cyc);
  endtask

  task automatic test_mid_reset();
    int cyc;
    rand_img10();
    img10[4] = 10'h3ff;
    do_load(1'b0);
    @(negedge clk);
    sel = 1'b0; mode_s = 1'b1; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (20 + $urandom_range(0, 20)) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy10, done10, rd10, wr10} !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_flags: got %b required 0000", {busy10, done10, rd10, wr10});
    end
    n_cmp++;
    if ({sum10, pc10} !== 48'h0) begin
      n_bad++; $display("FAIL midrst_counts: got sum=%0d pass_cnt=%0d required 0", sum10, pc10);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_load(1'b0);
    run_check("after_rst", 1'b0, 1'b1, 0, cyc);
  endtask

  initial begin
    test_reset();
    test_example();
    test_small();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
